// File: rtl/e203_lsu_icb_splt.sv
// LSU ICB splitter: routes one upstream ICB to N_TGT targets by address region, keeps
// responses in order via an outstanding FIFO, and tracks the LR/SC reservation.
module e203_lsu_icb_splt #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned N_TGT    = 3,
    parameter int unsigned OUTS_NUM = 2,
    parameter int unsigned RGN_LSB  = 16,
    parameter int unsigned EXCL_TMO = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_icb_cmd_valid,
    output logic                          i_icb_cmd_ready,
    input  logic [AW-1:0]                 i_icb_cmd_addr,
    input  logic                          i_icb_cmd_read,
    input  logic [DW-1:0]                 i_icb_cmd_wdata,
    input  logic [DW/8-1:0]               i_icb_cmd_wmask,
    input  logic                          i_icb_cmd_excl,
    output logic                          i_icb_rsp_valid,
    input  logic                          i_icb_rsp_ready,
    output logic                          i_icb_rsp_err,
    output logic                          i_icb_rsp_excl_ok,
    output logic [DW-1:0]                 i_icb_rsp_rdata,
    output logic [N_TGT-1:0]              o_icb_cmd_valid,
    input  logic [N_TGT-1:0]              o_icb_cmd_ready,
    output logic [AW-1:0]                 o_icb_cmd_addr,
    output logic                          o_icb_cmd_read,
    output logic [DW-1:0]                 o_icb_cmd_wdata,
    output logic [DW/8-1:0]               o_icb_cmd_wmask,
    input  logic [N_TGT-1:0]              o_icb_rsp_valid,
    output logic [N_TGT-1:0]              o_icb_rsp_ready,
    input  logic [N_TGT-1:0]              o_icb_rsp_err,
    input  logic [N_TGT*DW-1:0]           o_icb_rsp_rdata,
    input  logic [N_TGT*(AW-RGN_LSB)-1:0] tgt_base,
    input  logic                          commit_flush
);

    localparam int unsigned RW  = AW - RGN_LSB;
    localparam int unsigned TW  = $clog2(N_TGT);
    localparam int unsigned PW  = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
    localparam int unsigned CW  = $clog2(OUTS_NUM + 1);
    localparam int unsigned TMW = (EXCL_TMO > 1) ? $clog2(EXCL_TMO) : 1;
    localparam bit          TMO_EN = (EXCL_TMO != 0);

    logic [TW-1:0]  fifo_tgt_q [OUTS_NUM];
    logic           fifo_sc_q  [OUTS_NUM];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  cnt_q;
    logic [TW-1:0]  last_tgt_q;
    logic           excl_flg_q, excl_flg_d;
    logic [AW-1:0]  excl_addr_q, excl_addr_d;
    logic [TMW-1:0] timer_q, timer_d;

    logic [TW-1:0] tgt, head_tgt;
    logic          head_sc, empty, full, go;
    logic          cmd_hsk, rsp_hsk, scond_true, sc_fail;
    logic          lr_set, st_clr, tmo_clr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTS_NUM - 1)) ? '0 : p + 1'b1;
    endfunction

    // Descending scan so the lowest matching region wins; last target is the default.
    always_comb begin
        tgt = TW'(N_TGT - 1);
        for (int k = N_TGT - 2; k >= 0; k--) begin
            if (i_icb_cmd_addr[AW-1:RGN_LSB] == tgt_base[k*RW +: RW]) tgt = TW'(k);
        end
    end

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(OUTS_NUM));
    assign go    = ~full & (empty | (tgt == last_tgt_q));

    always_comb begin
        o_icb_cmd_valid = '0;
        for (int k = 0; k < N_TGT; k++) begin
            o_icb_cmd_valid[k] = i_icb_cmd_valid & go & (tgt == TW'(k));
        end
    end

    assign i_icb_cmd_ready = o_icb_cmd_ready[tgt] & go;
    assign cmd_hsk         = i_icb_cmd_valid & i_icb_cmd_ready;

    assign scond_true = i_icb_cmd_excl & ~i_icb_cmd_read & excl_flg_q
                      & (i_icb_cmd_addr == excl_addr_q);
    assign sc_fail    = i_icb_cmd_excl & ~i_icb_cmd_read & ~scond_true;

    assign o_icb_cmd_addr  = i_icb_cmd_addr;
    assign o_icb_cmd_read  = i_icb_cmd_read;
    assign o_icb_cmd_wdata = i_icb_cmd_wdata;
    assign o_icb_cmd_wmask = sc_fail ? '0 : i_icb_cmd_wmask;

    assign head_tgt          = fifo_tgt_q[rptr_q];
    assign head_sc           = fifo_sc_q[rptr_q];
    assign i_icb_rsp_valid   = ~empty & o_icb_rsp_valid[head_tgt];
    assign i_icb_rsp_excl_ok = head_sc;
    assign rsp_hsk           = i_icb_rsp_valid & i_icb_rsp_ready;

    always_comb begin
        o_icb_rsp_ready = '0;
        i_icb_rsp_err   = 1'b0;
        i_icb_rsp_rdata = '0;
        for (int k = 0; k < N_TGT; k++) begin
            if (head_tgt == TW'(k)) begin
                o_icb_rsp_ready[k] = i_icb_rsp_ready & ~empty;
                i_icb_rsp_err      = o_icb_rsp_err[k];
                i_icb_rsp_rdata    = o_icb_rsp_rdata[k*DW +: DW];
            end
        end
    end

    // A new LR takes priority over any clearing event in the same cycle.
    always_comb begin
        lr_set      = cmd_hsk & i_icb_cmd_read & i_icb_cmd_excl;
        st_clr      = cmd_hsk & ~i_icb_cmd_read & excl_flg_q & (i_icb_cmd_addr == excl_addr_q);
        tmo_clr     = TMO_EN & excl_flg_q & (timer_q == TMW'(EXCL_TMO - 1));
        excl_flg_d  = lr_set | (excl_flg_q & ~(st_clr | commit_flush | tmo_clr));
        excl_addr_d = lr_set ? i_icb_cmd_addr : excl_addr_q;
        timer_d     = (lr_set | ~excl_flg_d) ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUTS_NUM; i++) begin
                fifo_tgt_q[i] <= '0;
                fifo_sc_q[i]  <= 1'b0;
            end
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            last_tgt_q  <= '0;
            excl_flg_q  <= 1'b0;
            excl_addr_q <= '0;
            timer_q     <= '0;
        end else begin
            if (cmd_hsk) begin
                fifo_tgt_q[wptr_q] <= tgt;
                fifo_sc_q[wptr_q]  <= scond_true;
                wptr_q             <= ptr_inc(wptr_q);
                last_tgt_q         <= tgt;
            end
            if (rsp_hsk) rptr_q <= ptr_inc(rptr_q);
            if (cmd_hsk & ~rsp_hsk) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (~cmd_hsk & rsp_hsk) begin
                cnt_q <= cnt_q - 1'b1;
            end
            excl_flg_q  <= excl_flg_d;
            excl_addr_q <= excl_addr_d;
            timer_q     <= timer_d;
        end
    end

endmodule

// File: tb/tb_e203_lsu_icb_splt.sv
// Directed bench for e203_lsu_icb_splt: a target model answers commands, and a monitor
// compares every upstream response against a scoreboard filled at command issue.
module tb_e203_lsu_icb_splt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_icb_cmd_valid = 1'b0;
    logic        i_icb_cmd_ready;
    logic [31:0] i_icb_cmd_addr = '0;
    logic        i_icb_cmd_read = 1'b0;
    logic [31:0] i_icb_cmd_wdata = '0;
    logic [3:0]  i_icb_cmd_wmask = '0;
    logic        i_icb_cmd_excl = 1'b0;
    logic        i_icb_rsp_valid;
    logic        i_icb_rsp_ready = 1'b1;
    logic        i_icb_rsp_err;
    logic        i_icb_rsp_excl_ok;
    logic [31:0] i_icb_rsp_rdata;
    logic [2:0]  o_icb_cmd_valid;
    logic [2:0]  o_icb_cmd_ready = 3'b111;
    logic [31:0] o_icb_cmd_addr;
    logic        o_icb_cmd_read;
    logic [31:0] o_icb_cmd_wdata;
    logic [3:0]  o_icb_cmd_wmask;
    logic [2:0]  o_icb_rsp_valid = '0;
    logic [2:0]  o_icb_rsp_ready;
    logic [2:0]  o_icb_rsp_err = '0;
    logic [95:0] o_icb_rsp_rdata = '0;
    logic [47:0] tgt_base = {16'h0000, 16'h9000, 16'h8000};
    logic        commit_flush = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [32:0] tq [3][$];  // per-target pending {err, rdata}
    logic [33:0] sb [$];     // expected {err, rdata, excl_ok}
    logic [2:0]  rsp_en = '0;

    e203_lsu_icb_splt dut (
        .clk               (clk),
        .rst               (rst),
        .i_icb_cmd_valid   (i_icb_cmd_valid),
        .i_icb_cmd_ready   (i_icb_cmd_ready),
        .i_icb_cmd_addr    (i_icb_cmd_addr),
        .i_icb_cmd_read    (i_icb_cmd_read),
        .i_icb_cmd_wdata   (i_icb_cmd_wdata),
        .i_icb_cmd_wmask   (i_icb_cmd_wmask),
        .i_icb_cmd_excl    (i_icb_cmd_excl),
        .i_icb_rsp_valid   (i_icb_rsp_valid),
        .i_icb_rsp_ready   (i_icb_rsp_ready),
        .i_icb_rsp_err     (i_icb_rsp_err),
        .i_icb_rsp_excl_ok (i_icb_rsp_excl_ok),
        .i_icb_rsp_rdata   (i_icb_rsp_rdata),
        .o_icb_cmd_valid   (o_icb_cmd_valid),
        .o_icb_cmd_ready   (o_icb_cmd_ready),
        .o_icb_cmd_addr    (o_icb_cmd_addr),
        .o_icb_cmd_read    (o_icb_cmd_read),
        .o_icb_cmd_wdata   (o_icb_cmd_wdata),
        .o_icb_cmd_wmask   (o_icb_cmd_wmask),
        .o_icb_rsp_valid   (o_icb_rsp_valid),
        .o_icb_rsp_ready   (o_icb_rsp_ready),
        .o_icb_rsp_err     (o_icb_rsp_err),
        .o_icb_rsp_rdata   (o_icb_rsp_rdata),
        .tgt_base          (tgt_base),
        .commit_flush      (commit_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Target model: presents its oldest pending response when enabled.
    always begin : target_model
        logic [2:0] hs;
        @(negedge clk);
        hs = o_icb_rsp_valid & o_icb_rsp_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (hs[k] && tq[k].size() > 0) void'(tq[k].pop_front());
            if (tq[k].size() > 0) begin
                o_icb_rsp_valid[k]         = rsp_en[k];
                o_icb_rsp_err[k]           = tq[k][0][32];
                o_icb_rsp_rdata[k*32 +: 32] = tq[k][0][31:0];
            end else begin
                o_icb_rsp_valid[k] = 1'b0;
                o_icb_rsp_err[k]   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && i_icb_rsp_valid && i_icb_rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", {30'b0, i_icb_rsp_err, i_icb_rsp_excl_ok, 1'b1}, 64'h0);
            end else begin
                check("rsp", {i_icb_rsp_err, i_icb_rsp_rdata, i_icb_rsp_excl_ok}, sb.pop_front());
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                         input logic [3:0] wm, input logic ex);
        i_icb_cmd_addr  = a;
        i_icb_cmd_read  = rd;
        i_icb_cmd_wdata = wd;
        i_icb_cmd_wmask = wm;
        i_icb_cmd_excl  = ex;
        i_icb_cmd_valid = 1'b1;
    endtask

    task automatic accept(input int t, input logic [32:0] rsp, input logic ok);
        i_icb_cmd_valid = 1'b0;
        tq[t].push_back(rsp);
        sb.push_back({rsp, ok});
    endtask

    task automatic wait_accept(input string nm, input int t, input logic [32:0] rsp,
                               input logic ok, input logic [3:0] exp_wm);
        int  n = 0;
        bit  got = 0;
        logic [2:0] ov;
        ov = 3'b001 << t;
        while (!got && n < 100) begin
            @(negedge clk);
            if (i_icb_cmd_ready === 1'b1) got = 1;
            else n++;
        end
        check({nm, "_accept"}, {63'b0, got}, 64'h1);
        if (got) begin
            check({nm, "_valid"}, {61'b0, o_icb_cmd_valid}, {61'b0, ov});
            check({nm, "_wmask"}, {60'b0, o_icb_cmd_wmask}, {60'b0, exp_wm});
            check({nm, "_addr"}, {32'b0, o_icb_cmd_addr}, {32'b0, i_icb_cmd_addr});
            step();
            accept(t, rsp, ok);
        end else begin
            step();
            i_icb_cmd_valid = 1'b0;
        end
    endtask

    task automatic issue(input string nm, input logic [31:0] a, input logic rd,
                         input logic [31:0] wd, input logic [3:0] wm, input logic ex,
                         input int t, input logic [32:0] rsp, input logic ok,
                         input logic [3:0] exp_wm);
        drive(a, rd, wd, wm, ex);
        wait_accept(nm, t, rsp, ok, exp_wm);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drain"}, sb.size(), 0);
        step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_valid", {61'b0, o_icb_cmd_valid}, 0);
        check("rst_rsp_valid", {63'b0, i_icb_rsp_valid}, 0);
        check("rst_rsp_ready", {61'b0, o_icb_rsp_ready}, 0);
        step();
        rst = 1'b0;

        // Single load with only target 0 ready
        o_icb_cmd_ready = 3'b001;
        rsp_en = 3'b111;
        issue("ld_t0", 32'h8000_0010, 1, 0, 4'h0, 0, 0, {1'b0, 32'h0000_1234}, 0, 4'h0);
        wait_drain("t1");
        o_icb_cmd_ready = 3'b111;

        // Lowest matching region wins
        tgt_base = {16'h8000, 16'h8000, 16'h8000};
        issue("prio", 32'h8000_0100, 1, 0, 4'h0, 0, 0, {1'b0, 32'h0000_0777}, 0, 4'h0);
        tgt_base = {16'h0000, 16'h8000, 16'h1111};
        issue("prio1", 32'h8000_0104, 1, 0, 4'h0, 0, 1, {1'b0, 32'h0000_0778}, 0, 4'h0);
        wait_drain("prio");
        tgt_base = {16'h0000, 16'h9000, 16'h8000};

        // Target switch stalls until both tgt0 responses have popped
        rsp_en = 3'b000;
        issue("sw_a", 32'h8000_0020, 1, 0, 4'h0, 0, 0, {1'b0, 32'hAAAA_0000}, 0, 4'h0);
        issue("sw_b", 32'h8000_0030, 1, 0, 4'h0, 0, 0, {1'b0, 32'hBBBB_0000}, 0, 4'h0);
        drive(32'h2000_0000, 1, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sw_stall_rdy", {63'b0, i_icb_cmd_ready}, 0);
            check("sw_stall_vld", {61'b0, o_icb_cmd_valid}, 0);
            step();
        end
        rsp_en = 3'b111;
        wait_accept("sw_c", 2, {1'b0, 32'hCCCC_0000}, 0, 4'h0);
        check("sw_order", sb.size(), 1);
        wait_drain("t2");

        // Full FIFO: stall, no pass-through on pop, push+pop keeps count
        rsp_en = 3'b001;
        i_icb_rsp_ready = 1'b0;
        issue("f_d1", 32'h8000_0100, 1, 0, 4'h0, 0, 0, {1'b0, 32'hD1}, 0, 4'h0);
        issue("f_d2", 32'h8000_0104, 1, 0, 4'h0, 0, 0, {1'b0, 32'hD2}, 0, 4'h0);
        drive(32'h8000_0108, 1, 0, 4'h0, 0);
        @(negedge clk);
        check("full_stall", {63'b0, i_icb_cmd_ready}, 0);
        step();
        i_icb_rsp_ready = 1'b1;
        @(negedge clk);
        check("full_rsp_v", {63'b0, i_icb_rsp_valid}, 1);
        check("full_before_pop", {63'b0, i_icb_cmd_ready}, 0);
        step();
        @(negedge clk);
        check("push_with_pop", {63'b0, i_icb_cmd_ready}, 1);
        check("pop_with_push", {63'b0, i_icb_rsp_valid}, 1);
        step();
        accept(0, {1'b0, 32'hD3}, 0);
        i_icb_rsp_ready = 1'b0;
        drive(32'h8000_010C, 1, 0, 4'h0, 0);
        @(negedge clk);
        check("push_at_one", {63'b0, i_icb_cmd_ready}, 1);
        step();
        accept(0, {1'b0, 32'hD4}, 0);
        drive(32'h8000_0110, 1, 0, 4'h0, 0);
        @(negedge clk);
        check("full_at_two", {63'b0, i_icb_cmd_ready}, 0);
        step();
        i_icb_rsp_ready = 1'b1;
        rsp_en = 3'b111;
        wait_accept("f_d5", 0, {1'b0, 32'hD5}, 0, 4'h0);
        wait_drain("t3");

        // LR / SC pairing, plain store, error response
        issue("lr", 32'h9000_0040, 1, 0, 4'h0, 1, 1, {1'b0, 32'hAAAA_0001}, 0, 4'h0);
        issue("sc_ok", 32'h9000_0040, 0, 32'h55, 4'hF, 1, 1, {1'b0, 32'h0}, 1, 4'hF);
        issue("sc_again", 32'h9000_0040, 0, 32'h66, 4'hF, 1, 1, {1'b0, 32'h0}, 0, 4'h0);
        issue("st_plain", 32'h9000_0044, 0, 32'h77, 4'h3, 0, 1, {1'b0, 32'h0}, 0, 4'h3);
        issue("ld_err", 32'h2000_0000, 1, 0, 4'h0, 0, 2, {1'b1, 32'h0000_0BAD}, 0, 4'h0);
        wait_drain("t4");

        issue("lr2", 32'h9000_0040, 1, 0, 4'h0, 1, 1, {1'b0, 32'h2}, 0, 4'h0);
        issue("sc_other", 32'h9000_0048, 0, 1, 4'hF, 1, 1, {1'b0, 32'h0}, 0, 4'h0);
        issue("sc_still", 32'h9000_0040, 0, 1, 4'hF, 1, 1, {1'b0, 32'h0}, 1, 4'hF);
        issue("lr3", 32'h9000_0040, 1, 0, 4'h0, 1, 1, {1'b0, 32'h3}, 0, 4'h0);
        issue("st_kill", 32'h9000_0040, 0, 1, 4'hF, 0, 1, {1'b0, 32'h0}, 0, 4'hF);
        issue("sc_killed", 32'h9000_0040, 0, 1, 4'hF, 1, 1, {1'b0, 32'h0}, 0, 4'h0);

        // Reservation lifetime boundary: 63 idle cycles keeps it, 64 loses it
        issue("lr_t1", 32'h9000_0040, 1, 0, 4'h0, 1, 1, {1'b0, 32'h4}, 0, 4'h0);
        repeat (63) step();
        issue("sc_t63", 32'h9000_0040, 0, 1, 4'hF, 1, 1, {1'b0, 32'h0}, 1, 4'hF);
        issue("lr_t2", 32'h9000_0040, 1, 0, 4'h0, 1, 1, {1'b0, 32'h5}, 0, 4'h0);
        repeat (64) step();
        issue("sc_t64", 32'h9000_0040, 0, 1, 4'hF, 1, 1, {1'b0, 32'h0}, 0, 4'h0);

        // commit_flush after LR kills it; together with LR the set wins
        issue("lr_f", 32'h9000_0040, 1, 0, 4'h0, 1, 1, {1'b0, 32'h6}, 0, 4'h0);
        commit_flush = 1'b1;
        step();
        commit_flush = 1'b0;
        issue("sc_flushed", 32'h9000_0040, 0, 1, 4'hF, 1, 1, {1'b0, 32'h0}, 0, 4'h0);
        commit_flush = 1'b1;
        issue("lr_fsame", 32'h9000_0040, 1, 0, 4'h0, 1, 1, {1'b0, 32'h7}, 0, 4'h0);
        commit_flush = 1'b0;
        issue("sc_fsame", 32'h9000_0040, 0, 1, 4'hF, 1, 1, {1'b0, 32'h0}, 1, 4'hF);
        wait_drain("t5");

        // Reset with a load outstanding: the late target response is not accepted
        rsp_en = 3'b000;
        issue("ld_rst", 32'h8000_0200, 1, 0, 4'h0, 0, 0, {1'b0, 32'hDEAD_0000}, 0, 4'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        rsp_en = 3'b001;
        step();
        @(negedge clk);
        check("rst_late_vld", {63'b0, i_icb_rsp_valid}, 0);
        check("rst_late_rdy", {61'b0, o_icb_rsp_ready}, 0);
        step();
        step();
        rsp_en = 3'b000;
        for (int k = 0; k < 3; k++) tq[k].delete();
        step();
        step();
        check("end_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e203_lsu_icb_splt.md
E203_LSU_ICB_SPLT -- requirements
Module: e203_lsu_icb_splt

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter N_TGT, default 3, number of downstream targets (>=2).
REQ-004 SHALL have parameter OUTS_NUM, default 2, maximum outstanding transactions (>=1).
REQ-005 SHALL have parameter RGN_LSB, default 16, lowest address bit used for region decode.
REQ-006 SHALL have parameter EXCL_TMO, default 64, reservation lifetime in cycles; 0 disables the timeout.
REQ-007 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-009 SHALL have port i_icb_cmd_valid  in  1  upstream command valid.
REQ-010 SHALL have port i_icb_cmd_ready  out  1  upstream command ready.
REQ-011 SHALL have port i_icb_cmd_addr  in  AW  command address.
REQ-012 SHALL have port i_icb_cmd_read  in  1  1=load, 0=store.
REQ-013 SHALL have port i_icb_cmd_wdata  in  DW  store data.
REQ-014 SHALL have port i_icb_cmd_wmask  in  DW/8  store byte mask.
REQ-015 SHALL have port i_icb_cmd_excl  in  1  exclusive access (LR when read, SC when store).
REQ-016 SHALL have port i_icb_rsp_valid  out  1  upstream response valid.
REQ-017 SHALL have port i_icb_rsp_ready  in  1  upstream response ready.
REQ-018 SHALL have port i_icb_rsp_err  out  1  response error.
REQ-019 SHALL have port i_icb_rsp_excl_ok  out  1  SC success flag for this response.
REQ-020 SHALL have port i_icb_rsp_rdata  out  DW  load data.
REQ-021 SHALL have port o_icb_cmd_valid  out  N_TGT  per-target command valid (at most one bit set).
REQ-022 SHALL have port o_icb_cmd_ready  in  N_TGT  per-target command ready.
REQ-023 SHALL have port o_icb_cmd_addr  out  AW  address broadcast to all targets.
REQ-024 SHALL have port o_icb_cmd_read  out  1  read flag broadcast.
REQ-025 SHALL have port o_icb_cmd_wdata  out  DW  write data broadcast.
REQ-026 SHALL have port o_icb_cmd_wmask  out  DW/8  write mask broadcast, post SC-fail suppression.
REQ-027 SHALL have port o_icb_rsp_valid  in  N_TGT  per-target response valid.
REQ-028 SHALL have port o_icb_rsp_ready  out  N_TGT  per-target response ready.
REQ-029 SHALL have port o_icb_rsp_err  in  N_TGT  per-target response error.
REQ-030 SHALL have port o_icb_rsp_rdata  in  N_TGT*DW  per-target read data, target k at bits [k*DW +: DW].
REQ-031 SHALL have port tgt_base  in  N_TGT*(AW-RGN_LSB)  region tag of each target (entry N_TGT-1 unused).
REQ-032 SHALL have port commit_flush  in  1  trap or mret committed; kills the reservation.

Function
REQ-033 Target decode SHALL pick the lowest k<N_TGT-1 with addr[AW-1:RGN_LSB]==tgt_base[k]; with no match it SHALL pick N_TGT-1 (BIU default).
REQ-034 Command path SHALL be combinational, zero latency: go = ~full & (empty | tgt==last_tgt); o_icb_cmd_valid[tgt]=i_icb_cmd_valid&go; i_icb_cmd_ready=o_icb_cmd_ready[tgt]&go.
REQ-035 Commands to a target different from the one with outstanding entries SHALL stall until the FIFO drains, so responses stay in order.
REQ-036 Outstanding FIFO SHALL hold OUTS_NUM entries {tgt index, scond_true}; push on cmd handshake, pop on upstream rsp handshake; pointers wrap modulo OUTS_NUM; simultaneous push+pop leaves count unchanged; full is evaluated before pop (no same-cycle pass-through when full).
REQ-037 Response routing: i_icb_rsp_valid=~empty&o_icb_rsp_valid[head.tgt]; o_icb_rsp_ready[k]=i_icb_rsp_ready&~empty&(k==head.tgt); err/rdata muxed from head.tgt; i_icb_rsp_excl_ok=head.scond_true; non-head targets see ready 0.
REQ-038 LR (read&excl handshake) SHALL set excl_flg=1, latch excl_addr=addr, clear the timer.
REQ-039 scond_true = excl & ~read & excl_flg & (addr==excl_addr); a failing SC SHALL still be issued with o_icb_cmd_wmask=0.
REQ-040 excl_flg SHALL clear on: any store handshake with addr==excl_addr while flagged; commit_flush; timer reaching EXCL_TMO-1 (EXCL_TMO>0); set wins over clear in the same cycle.
REQ-041 Timer SHALL increment each cycle while excl_flg=1 and hold at 0 otherwise.

Reset
REQ-042 On rst: FIFO empty, last_tgt=0, excl_flg=0, excl_addr=0, timer=0, hence o_icb_cmd_valid=0, o_icb_rsp_ready=0, i_icb_rsp_valid=0; reset mid-transaction discards outstanding entries and late target responses are not accepted.

Verification
REQ-043 Load 0x8000_0010 (tgt_base[0]=0x8000) with o_icb_cmd_ready=3'b001 -> o_icb_cmd_valid=3'b001 same cycle; rsp rdata 0x1234 returned on i_icb_rsp_rdata.
REQ-044 Two loads to tgt0 then one to 0x2000_0000 (tgt2) -> third stalls (i_icb_cmd_ready=0) until both tgt0 responses pop.
REQ-045 OUTS_NUM=2 with no responses -> third command to tgt0 stalls; rsp pop plus new push in the same cycle keeps count at 2.
REQ-046 LR 0x9000_0040, then SC same address -> excl_ok=1, wmask 4'hF; second SC -> excl_ok=0, wmask 4'h0.
REQ-047 LR, then 64 idle cycles (EXCL_TMO=64), or commit_flush pulse -> following SC fails; LR with commit_flush in the same cycle -> flag remains 1.
